pc_sequencer: RTL
=================

# pc_sequencer

Instruction-fetch sequencer for the MIPS core. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and hands fetched instructions to decode over a valid/ready handshake. Takes branch and jump redirects from decode and computes their targets itself (PC' = PC + 4 + SignImm * 4 for beq/bne, pseudo-direct for j). An outstanding fetch is squashed cleanly when a redirect hits it.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch word address; stable while imem_req is high.
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req is low.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr_ready  in  1  decode accepts when high together with instr_valid.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- branch_taken  in  1  one-cycle pulse: taken conditional branch.
- jump  in  1  one-cycle pulse: unconditional jump.
- br_pcplus4  in  32  PC+4 of the redirecting instruction.
- signimm  in  32  sign-extended branch offset in words.
- jump_index  in  26  j-format instr_index field.

## Operation
- States: IDLE, FETCH, VALID, DISCARD. Registers: pc, fetch_addr, instr, instr_pc.
- IDLE (reset state): next edge -> FETCH with fetch_addr <= pc.
- imem_req = (state == FETCH) or (state == DISCARD). imem_addr = fetch_addr.
- FETCH, imem_ack=1, no redirect: instr <= imem_rdata, instr_pc <= fetch_addr, pc <= fetch_addr + 4, -> VALID.
- FETCH, imem_ack=0: stay in FETCH; req and addr unchanged.
- VALID: instr_valid=1. If instr_ready=1: -> FETCH with fetch_addr <= pc. Else hold.
- Redirect (branch_taken or jump high in any state). Targets use 32-bit arithmetic with carry discarded:
  - Branch target: br_pcplus4 + (signimm << 2), truncated to 32 bits.
  - Jump target: {br_pcplus4[31:28], jump_index, 2'b00}.
  - If both are high, jump wins.
  - pc <= target in every case.
- Redirect by state:
  - IDLE: -> FETCH with fetch_addr <= target.
  - FETCH with imem_ack=1: returned data dropped; -> FETCH with fetch_addr <= target.
  - FETCH with imem_ack=0: -> DISCARD. fetch_addr is unchanged, so the handshake completes at the old address.
  - VALID: instruction squashed (instr_valid low next cycle); -> FETCH with fetch_addr <= target. If instr_ready was also high that cycle, decode consumes the instruction first.
- DISCARD: imem_req held high at the old fetch_addr.
  - On imem_ack: data dropped; -> FETCH with fetch_addr <= pc.
  - Further redirects only update pc.
- imem_req never drops before imem_ack. imem_addr never changes while imem_req is high.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc=RESET_PC, state IDLE.
- Reset is asynchronous: outputs take their reset values immediately, even mid-handshake. Memory must tolerate a request abandoned by reset.
- First imem_req goes high the cycle after the first rising edge following rst_n deassertion.
- Zero-wait memory (ack in the same cycle as req): instr_valid rises the next cycle.
- Peak throughput: one instruction per 2 cycles (FETCH, VALID).
- Redirect-to-new-fetch latency:
  - 1 cycle from IDLE, VALID, or FETCH with ack.
  - Otherwise, 1 cycle after the outstanding ack.

## Configuration
- REDIRECT_COUNT_EN defined: adds output redirect_count (16-bit).
  - Reset value 0.
  - Increments on every cycle with branch_taken or jump high.
  - Saturates at 16'hFFFF.
- REDIRECT_COUNT_EN undefined: the port and counter are absent. Fetch behaviour is identical either way.

## Test plan
- Reset release, RESET_PC=32'h0040_0000, zero-wait memory, instr_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid every other cycle; instr_pc matches each address.
- Memory acks 3 cycles late -> imem_req stays high and imem_addr stays 0x00400000 for all 3 cycles; exactly one instruction is delivered.
- branch_taken in VALID, br_pcplus4=0x00400010, signimm=0xFFFFFFFE -> held instruction squashed; next fetch at 0x00400008.
- jump while FETCH is waiting, jump_index=26'h0000100, br_pcplus4=0x00400008 -> DISCARD until ack; old data never presented; next fetch at 0x00000400.
- branch_taken and jump in the same cycle -> jump target used. br_pcplus4=0xFFFFFFFC with signimm=1 -> target wraps to 0x00000000.
- rst_n asserted mid-wait -> imem_req and instr_valid drop immediately; fetch restarts at RESET_PC. With REDIRECT_COUNT_EN, 70000 redirects -> redirect_count reads 16'hFFFF.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: instruction-memory req/ack, decode valid/ready
// and the branch/jump redirect inputs coming back from decode.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        branch_taken;
    logic        jump;
    logic [31:0] br_pcplus4;
    logic [31:0] signimm;
    logic [25:0] jump_index;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready,
        input  branch_taken, jump, br_pcplus4, signimm, jump_index
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready,
        output branch_taken, jump, br_pcplus4, signimm, jump_index
    );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS instruction-fetch sequencer: owns the PC, fetches words over req/ack and presents them
// to decode over valid/ready, squashing fetches hit by a redirect. Macro REDIRECT_COUNT_EN adds redirect_count.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_sequencer_if.master    bus
`ifdef REDIRECT_COUNT_EN
    ,
    output logic [15:0]       redirect_count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        redirect;
    logic [31:0] target;

    function automatic logic [31:0] branch_target(input logic [31:0] pcplus4,
                                                  input logic signed [31:0] imm);
        logic signed [31:0] offset;
        offset = imm <<< 2;
        return pcplus4 + offset;
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [25:0] index);
        return {pcplus4[31:28], index, 2'b00};
    endfunction

    assign redirect = bus.branch_taken | bus.jump;
    assign target   = bus.jump ? jump_target(bus.br_pcplus4, bus.jump_index)
                               : branch_target(bus.br_pcplus4, bus.signimm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            instr_q      <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    // A redirect while the fetch is still unacknowledged must park in DISCARD so the
    // address stays put until memory completes the old handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                if (redirect)          state_d = bus.imem_ack ? FETCH : DISCARD;
                else if (bus.imem_ack) state_d = VALID;
            end
            VALID: begin
                if (redirect || bus.instr_ready) state_d = FETCH;
            end
            DISCARD: begin
                if (bus.imem_ack) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every new fetch launches from pc_d, which already carries any same-cycle redirect target.
    always_comb begin
        pc_d         = redirect ? target : pc_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        case (state_q)
            IDLE: fetch_addr_d = pc_d;
            FETCH: begin
                if (redirect) begin
                    if (bus.imem_ack) fetch_addr_d = pc_d;
                end else if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = fetch_addr_q;
                    pc_d       = fetch_addr_q + 32'd4;
                end
            end
            VALID: begin
                if (redirect || bus.instr_ready) fetch_addr_d = pc_d;
            end
            DISCARD: begin
                if (bus.imem_ack) fetch_addr_d = pc_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == FETCH) || (state_q == DISCARD);
        bus.imem_addr   = fetch_addr_q;
        bus.instr_valid = (state_q == VALID);
        bus.instr       = instr_q;
        bus.instr_pc    = instr_pc_q;
    end

`ifdef REDIRECT_COUNT_EN
    logic [15:0] redirect_count_q, redirect_count_d;

    always_comb begin
        redirect_count_d = redirect_count_q;
        if (redirect && (redirect_count_q != 16'hFFFF))
            redirect_count_d = redirect_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) redirect_count_q <= '0;
        else        redirect_count_q <= redirect_count_d;
    end

    assign redirect_count = redirect_count_q;
`endif

endmodule
